// File: rtl/switch_allocator_if.sv
// rtl/switch_allocator_if.sv - request, flit handshake and grant bundle for the switch allocator
// master drives requests and flit handshakes; slave is the allocator.
interface switch_allocator_if #(
   parameter int INPUTS        = 4,
   parameter int OUTPUTS       = 4,
   parameter int REQUEST_WIDTH = 32
);
   logic [INPUTS*REQUEST_WIDTH-1:0]  request;
   logic [INPUTS-1:0]                request_valid;
   logic [INPUTS-1:0]                valid_in;
   logic [INPUTS-1:0]                ready_in;
   logic [INPUTS-1:0]                tail_in;
   logic [OUTPUTS*REQUEST_WIDTH-1:0] routeSelect;
   logic [OUTPUTS-1:0]               outputBusy;
   logic [INPUTS-1:0]                PortReserved;
   logic [OUTPUTS-1:0]               watchdog_err;

   modport master (
      output request, request_valid, valid_in, ready_in, tail_in,
      input  routeSelect, outputBusy, PortReserved, watchdog_err
   );

   modport slave (
      input  request, request_valid, valid_in, ready_in, tail_in,
      output routeSelect, outputBusy, PortReserved, watchdog_err
   );
endinterface

// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - per-output round-robin switch allocator with packet-long reservations
// Optional per-output stall watchdog is built when ALLOC_WATCHDOG_EN is defined.
module switch_allocator #(
   parameter int INPUTS          = 4,
   parameter int OUTPUTS         = 4,
   parameter int REQUEST_WIDTH   = 32,
   parameter int WATCHDOG_CYCLES = 255
) (
   input  logic               clk,
   input  logic               rst,
   switch_allocator_if.slave  alloc
);
   localparam int IW = (INPUTS > 1) ? $clog2(INPUTS) : 1;
   localparam int RW = REQUEST_WIDTH;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t                        state       [OUTPUTS];
   state_t                        state_next  [OUTPUTS];
   logic [IW-1:0]                 winner      [OUTPUTS];
   logic [IW-1:0]                 winner_next [OUTPUTS];
   logic [IW-1:0]                 rr          [OUTPUTS];
   logic [IW-1:0]                 rr_next     [OUTPUTS];
   logic [IW-1:0]                 pick        [OUTPUTS];
   logic [OUTPUTS-1:0]            found;
   logic [OUTPUTS-1:0][INPUTS-1:0] eligible;
   logic [INPUTS-1:0]             reserved;
   logic [INPUTS-1:0]             reserved_next;
   logic [OUTPUTS-1:0]            hs;
   logic [OUTPUTS-1:0]            tail_release;
   logic [OUTPUTS-1:0]            release_req;
   logic [OUTPUTS-1:0]            busy_vec;
   logic [OUTPUTS*RW-1:0]         route_vec;

   function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
      return IW'((int'(base) + k) % INPUTS);
   endfunction

   // A field that matches no output index (>= OUTPUTS) is simply never eligible anywhere.
   always_comb begin
      for (int o = 0; o < OUTPUTS; o++) begin
         for (int i = 0; i < INPUTS; i++) begin
            eligible[o][i] = alloc.request_valid[i] && !reserved[i] &&
                             (alloc.request[i*RW +: RW] == RW'(o));
         end
      end
   end

   always_comb begin
      for (int o = 0; o < OUTPUTS; o++) begin
         found[o] = 1'b0;
         pick[o]  = '0;
         for (int k = 1; k <= INPUTS; k++) begin
            if (!found[o] && eligible[o][rr_index(rr[o], k)]) begin
               found[o] = 1'b1;
               pick[o]  = rr_index(rr[o], k);
            end
         end
      end
   end

   always_comb begin
      for (int o = 0; o < OUTPUTS; o++) begin
         hs[o]           = alloc.valid_in[winner[o]] & alloc.ready_in[winner[o]];
         tail_release[o] = (state[o] == BUSY) && hs[o] && alloc.tail_in[winner[o]];
      end
   end

`ifdef ALLOC_WATCHDOG_EN
   localparam int CW = $clog2(WATCHDOG_CYCLES + 1);

   logic [CW-1:0]      wd_cnt [OUTPUTS];
   logic [OUTPUTS-1:0] wd_fire;
   logic [OUTPUTS-1:0] wd_err;

   always_comb begin
      for (int o = 0; o < OUTPUTS; o++) begin
         wd_fire[o] = (state[o] == BUSY) && !hs[o] &&
                      (int'(wd_cnt[o]) + 1 >= WATCHDOG_CYCLES);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_err <= '0;
         for (int o = 0; o < OUTPUTS; o++) wd_cnt[o] <= '0;
      end else begin
         for (int o = 0; o < OUTPUTS; o++) begin
            if (state[o] != BUSY || hs[o] || wd_fire[o]) wd_cnt[o] <= '0;
            else                                          wd_cnt[o] <= wd_cnt[o] + 1'b1;
            if (wd_fire[o]) wd_err[o] <= 1'b1;
         end
      end
   end

   assign release_req        = tail_release | wd_fire;
   assign alloc.watchdog_err = wd_err;
`else
   assign release_req        = tail_release;
   assign alloc.watchdog_err = '0;
`endif

   // Grant and release of one input by two outputs in one cycle cannot collide: a reserved input is never eligible.
   always_comb begin
      reserved_next = reserved;
      for (int o = 0; o < OUTPUTS; o++) begin
         state_next[o]  = state[o];
         winner_next[o] = winner[o];
         rr_next[o]     = rr[o];
         case (state[o])
            IDLE: begin
               if (found[o]) begin
                  state_next[o]           = BUSY;
                  winner_next[o]          = pick[o];
                  rr_next[o]              = pick[o];
                  reserved_next[pick[o]]  = 1'b1;
               end
            end
            BUSY: begin
               if (release_req[o]) begin
                  state_next[o]            = IDLE;
                  reserved_next[winner[o]] = 1'b0;
               end
            end
            default: state_next[o] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reserved <= '0;
         for (int o = 0; o < OUTPUTS; o++) begin
            state[o]  <= IDLE;
            winner[o] <= '0;
            rr[o]     <= IW'(INPUTS - 1);
         end
      end else begin
         reserved <= reserved_next;
         for (int o = 0; o < OUTPUTS; o++) begin
            state[o]  <= state_next[o];
            winner[o] <= winner_next[o];
            rr[o]     <= rr_next[o];
         end
      end
   end

   always_comb begin
      busy_vec  = '0;
      route_vec = '0;
      for (int o = 0; o < OUTPUTS; o++) begin
         busy_vec[o]            = (state[o] == BUSY);
         route_vec[o*RW +: RW]  = RW'(winner[o]);
      end
   end

   assign alloc.outputBusy   = busy_vec;
   assign alloc.routeSelect  = route_vec;
   assign alloc.PortReserved = reserved;
endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - directed and randomized checks of switch_allocator against a reference model
// Define ALLOC_WATCHDOG_EN for the watchdog build; WATCHDOG_CYCLES is set to 8 here.
module tb_switch_allocator;
   localparam int NI = 4;
   localparam int NO = 4;
   localparam int RW = 32;
   localparam int WD = 8;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   switch_allocator_if #(.INPUTS(NI), .OUTPUTS(NO), .REQUEST_WIDTH(RW)) bus ();

   switch_allocator #(
      .INPUTS(NI), .OUTPUTS(NO), .REQUEST_WIDTH(RW), .WATCHDOG_CYCLES(WD)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .alloc (bus.slave)
   );

   // Reference model: which input owns each output, who won last, who holds a reservation.
   bit m_busy  [NO];
   int m_owner [NO];
   int m_last  [NO];
   bit m_err   [NO];
   int m_cnt   [NO];
   bit m_res   [NI];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] req_field(input int i);
      return bus.request[i*RW +: RW];
   endfunction

   task automatic model_step();
      bit nb [NO]; int nw [NO]; int nl [NO]; bit ne [NO]; int nc [NO]; bit nr [NI];
      if (rst) begin
         for (int o = 0; o < NO; o++) begin
            m_busy[o] = 0; m_owner[o] = 0; m_last[o] = NI - 1; m_err[o] = 0; m_cnt[o] = 0;
         end
         for (int i = 0; i < NI; i++) m_res[i] = 0;
         return;
      end
      for (int i = 0; i < NI; i++) nr[i] = m_res[i];
      for (int o = 0; o < NO; o++) begin
         nb[o] = m_busy[o]; nw[o] = m_owner[o]; nl[o] = m_last[o]; ne[o] = m_err[o]; nc[o] = m_cnt[o];
         if (m_busy[o]) begin
            int w = m_owner[o];
            bit h, rel;
            h   = bus.valid_in[w] && bus.ready_in[w];
            rel = h && bus.tail_in[w];
`ifdef ALLOC_WATCHDOG_EN
            nc[o] = h ? 0 : m_cnt[o] + 1;
            if (nc[o] >= WD) begin rel = 1; ne[o] = 1; end
            if (rel) nc[o] = 0;
`endif
            if (rel) begin nb[o] = 0; nr[w] = 0; end
         end else begin
            int best = -1;
            int bestd = NI;
            for (int i = 0; i < NI; i++) begin
               if (bus.request_valid[i] && !m_res[i] && req_field(i) == RW'(o)) begin
                  int d = (i - m_last[o] - 1 + 2 * NI) % NI;
                  if (d < bestd) begin bestd = d; best = i; end
               end
            end
            if (best >= 0) begin nb[o] = 1; nw[o] = best; nl[o] = best; nr[best] = 1; end
         end
      end
      for (int o = 0; o < NO; o++) begin
         m_busy[o] = nb[o]; m_owner[o] = nw[o]; m_last[o] = nl[o]; m_err[o] = ne[o]; m_cnt[o] = nc[o];
      end
      for (int i = 0; i < NI; i++) m_res[i] = nr[i];
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      for (int o = 0; o < NO; o++) begin
         check("busy",  64'(bus.outputBusy[o]), 64'(m_busy[o]));
         check("route", 64'(bus.routeSelect[o*RW +: RW]), 64'(m_owner[o]));
         check("wderr", 64'(bus.watchdog_err[o]), 64'(m_err[o]));
      end
      for (int i = 0; i < NI; i++) check("resv", 64'(bus.PortReserved[i]), 64'(m_res[i]));
   endtask

   task automatic clear_inputs();
      bus.request       = '0;
      bus.request_valid = '0;
      bus.valid_in      = '0;
      bus.ready_in      = '0;
      bus.tail_in       = '0;
   endtask

   task automatic set_req(input int i, input int o);
      bus.request[i*RW +: RW] = RW'(o);
      bus.request_valid[i]    = 1'b1;
   endtask

   task automatic tail_on(input int i);
      bus.valid_in[i] = 1'b1;
      bus.ready_in[i] = 1'b1;
      bus.tail_in[i]  = 1'b1;
   endtask

   int exp_w [6] = '{1, 3, 1, 3, 1, 3};

   initial begin
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      check("rst_busy",  64'(bus.outputBusy), 64'd0);
      check("rst_resv",  64'(bus.PortReserved), 64'd0);
      check("rst_route", 64'(|bus.routeSelect), 64'd0);
      check("rst_err",   64'(bus.watchdog_err), 64'd0);
      rst = 1'b0;

      // Single request, then tail release.
      set_req(0, 2);
      tick();
      check("first_busy",  64'(bus.outputBusy), 64'b0100);
      check("first_route", 64'(bus.routeSelect[2*RW +: RW]), 64'd0);
      check("first_resv",  64'(bus.PortReserved), 64'b0001);
      bus.request_valid = '0;
      tail_on(0);
      tick();
      clear_inputs();
      check("first_rel", 64'(bus.outputBusy), 64'd0);

      // Two contenders for output 0 alternate packet by packet.
      set_req(1, 0);
      set_req(3, 0);
      tick();
      for (int k = 0; k < 6; k++) begin
         check("rr_winner", 64'(bus.routeSelect[0 +: RW]), 64'(exp_w[k]));
         tail_on(exp_w[k]);
         if (k == 5) bus.request_valid = '0;
         tick();
         bus.valid_in = '0; bus.ready_in = '0; bus.tail_in = '0;
         check("rel_next", 64'(bus.outputBusy[0]), 64'd0);
         tick();
         if (k < 5) check("regrant_n2", 64'(bus.outputBusy[0]), 64'd1);
      end
      clear_inputs();

      // Out-of-range output index is ignored.
      bus.request[0 +: RW] = RW'(7);
      bus.request_valid[0] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("oor_busy", 64'(bus.outputBusy), 64'd0);
         check("oor_resv", 64'(bus.PortReserved), 64'd0);
      end
      clear_inputs();

      // Stalled winner: watchdog release or indefinite hold.
      set_req(2, 1);
      tick();
      check("stall_grant", 64'(bus.outputBusy), 64'b0010);
      bus.request_valid = '0;
      bus.valid_in[2] = 1'b1;
      for (int c = 1; c < WD; c++) begin
         tick();
         check("stall_hold", 64'(bus.outputBusy[1]), 64'd1);
      end
      tick();
`ifdef ALLOC_WATCHDOG_EN
      check("wd_release", 64'(bus.outputBusy[1]), 64'd0);
      check("wd_flag",    64'(bus.watchdog_err), 64'b0010);
`else
      for (int c = 0; c < 10; c++) tick();
      check("nowd_hold", 64'(bus.outputBusy[1]), 64'd1);
      check("nowd_flag", 64'(bus.watchdog_err), 64'd0);
`endif
      bus.valid_in = '0;

      // Reset with two outputs busy mid-packet.
      set_req(0, 2);
      set_req(3, 3);
      tick();
      bus.request_valid = '0;
      check("pre_rst_busy", 64'(bus.outputBusy[3:2]), 64'b11);
      bus.valid_in = '1; bus.ready_in = '1; bus.tail_in = '0;
      tick();
      bus.tail_in = '1;
      rst = 1'b1;
      tick();
      check("mid_rst_busy", 64'(bus.outputBusy), 64'd0);
      check("mid_rst_resv", 64'(bus.PortReserved), 64'd0);
      rst = 1'b0;
      clear_inputs();
      for (int i = 0; i < NI; i++) set_req(i, 0);
      tick();
      check("post_rst_first", 64'(bus.routeSelect[0 +: RW]), 64'd0);
      check("post_rst_resv",  64'(bus.PortReserved), 64'b0001);
      clear_inputs();
      tail_on(0);
      tick();
      clear_inputs();

      // Randomized traffic, including out-of-range fields and occasional reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < NI; i++) begin
            bus.request[i*RW +: RW] = RW'($urandom_range(0, 5));
            bus.request_valid[i]    = ($urandom_range(0, 3) != 0);
            bus.valid_in[i]         = $urandom_range(0, 1) == 1;
            bus.ready_in[i]         = $urandom_range(0, 1) == 1;
            bus.tail_in[i]          = ($urandom_range(0, 2) == 0);
         end
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0;
      clear_inputs();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
